// File: rtl/aes_key_expand.sv
// AES-128 key schedule: captures a cipher key and streams round keys 0..NR over a
// valid/ready handshake, holding only the current 4-word key.
module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, b;
    sq = x;
    b  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    if (x == 8'h00) b = 8'h00;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk_q[127:96];
    w1 = rk_q[95:64];
    w2 = rk_q[63:32];
    w3 = rk_q[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (valid_q && rk_ready) begin
          if (idx_q == 4'(NR)) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            rk_d   = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = valid_q;
  assign rk_index  = idx_q;
  assign round_key = rk_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
